// File: rtl/prog_loader_if.sv
// Byte-stream input and memory port-B load bus of the boot program loader.
// slave = the loader itself; master = the stream source / memory side.
interface prog_loader_if #(
  parameter int ADDR_W = 32
);
  logic              io_start;
  logic              io_byte_valid;
  logic [7:0]        io_byte_data;
  logic              io_byte_ready;
  logic [ADDR_W-1:0] io_load_addr;
  logic [7:0]        io_load_data_in_0;
  logic [7:0]        io_load_data_in_1;
  logic [7:0]        io_load_data_in_2;
  logic [7:0]        io_load_data_in_3;
  logic              io_load_we;
  logic              io_en_B;
  logic              io_core_hold;
  logic              io_done;
  logic              io_error;

  modport slave (
    input  io_start, io_byte_valid, io_byte_data,
    output io_byte_ready, io_load_addr,
           io_load_data_in_0, io_load_data_in_1, io_load_data_in_2, io_load_data_in_3,
           io_load_we, io_en_B, io_core_hold, io_done, io_error
  );

  modport master (
    output io_start, io_byte_valid, io_byte_data,
    input  io_byte_ready, io_load_addr,
           io_load_data_in_0, io_load_data_in_1, io_load_data_in_2, io_load_data_in_3,
           io_load_we, io_en_B, io_core_hold, io_done, io_error
  );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: 4-byte LE word count, then LE data words, one port-B write per word.
// Write is a registered one-cycle WRITE state after the 4th byte; ready drops for that cycle, valid low stalls anywhere.
module prog_loader #(
  parameter int MEM_SIZE = 1024,
  parameter int ADDR_W   = 32
) (
  input  logic        clock,
  input  logic        reset,
  prog_loader_if.slave bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LEN   = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [2:0] ERR   = 3'd5;

  logic [2:0]        state;
  logic [1:0]        byte_cnt;
  logic [31:0]       word_cnt;
  logic [31:0]       len_n;
  logic [ADDR_W-1:0] addr;
  logic [23:0]       shadow;
  logic [31:0]       lanes;
  logic              xfer;
  logic [31:0]       len_full;

  assign bus.io_byte_ready = (state == LEN) || (state == DATA);
  assign xfer              = bus.io_byte_valid && bus.io_byte_ready;
  assign len_full          = {bus.io_byte_data, len_n[23:0]};

  assign bus.io_load_we        = (state == WRITE);
  assign bus.io_en_B           = (state == WRITE);
  assign bus.io_load_addr      = addr;
  assign bus.io_load_data_in_0 = lanes[7:0];
  assign bus.io_load_data_in_1 = lanes[15:8];
  assign bus.io_load_data_in_2 = lanes[23:16];
  assign bus.io_load_data_in_3 = lanes[31:24];
  assign bus.io_done           = (state == DONE);
  assign bus.io_error          = (state == ERR);
  assign bus.io_core_hold      = (state != DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      byte_cnt <= 2'd0;
      word_cnt <= 32'd0;
      len_n    <= 32'd0;
      addr     <= '0;
      shadow   <= 24'd0;
      lanes    <= 32'd0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (bus.io_start) begin
            state    <= LEN;
            byte_cnt <= 2'd0;
            word_cnt <= 32'd0;
            len_n    <= 32'd0;
            addr     <= '0;
          end
        end
        LEN: begin
          if (xfer) begin
            len_n[{byte_cnt, 3'b000} +: 8] <= bus.io_byte_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (len_full == 32'd0)
                state <= DONE;
              else if (len_full > 32'(MEM_SIZE))
                state <= ERR;
              else
                state <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + 2'd1;
            // Output lanes only change when a full word is ready, so the
            // previous word stays visible while the next one assembles.
            if (byte_cnt == 2'd3) begin
              lanes <= {bus.io_byte_data, shadow};
              state <= WRITE;
            end else begin
              shadow[{byte_cnt, 3'b000} +: 8] <= bus.io_byte_data;
            end
          end
        end
        WRITE: begin
          addr     <= addr + ADDR_W'(1);
          word_cnt <= word_cnt + 32'd1;
          if (word_cnt + 32'd1 == len_n)
            state <= DONE;
          else
            state <= DATA;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
